// File: rtl/id_scoreboard.sv
// Register-dependency scoreboard for the decode stage: tracks in-flight writes per
// architectural register (GPRs, HI, LO) and gates instruction issue on RAW/WAW capacity.
module id_scoreboard #(
    parameter int unsigned NUM_REGS  = 34,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [ADDR_W-1:0]         dst_addr,
    input  logic                      dst_en,
    input  logic                      hilo_we,
    input  logic                      wb_valid,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic                      wb_hilo,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic                      err_underflow,
    output logic [31:0]               stall_cycles
);

    localparam int unsigned HI_REG = 32;
    localparam int unsigned LO_REG = 33;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] dst_hit;
    logic [NUM_SRC-1:0]  src_hazard;
    logic                dst_full;
    logic                issue;
    logic                underflow;

    // Register 0 is hardwired and never tracked; addresses >= NUM_REGS never match any r.
    always_comb begin
        wb_hit     = '0;
        dst_hit    = '0;
        src_hazard = '0;
        dst_full   = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_hit[r]  = (r != 0) && wb_valid &&
                         ((wb_addr == ADDR_W'(r)) || (wb_hilo && (r == HI_REG || r == LO_REG)));
            dst_hit[r] = (r != 0) &&
                         ((dst_en && dst_addr == ADDR_W'(r)) ||
                          (hilo_we && (r == HI_REG || r == LO_REG)));
            // A same-cycle retire never relieves a full counter.
            if (dst_hit[r] && cnt_q[r] == CNT_MAX) begin
                dst_full = 1'b1;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((r != 0) && src_en[i] && src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
                    cnt_q[r] != '0 &&
                    !(WB_BYPASS && wb_hit[r] && cnt_q[r] == CNT_ONE)) begin
                    src_hazard[i] = 1'b1;
                end
            end
        end
    end

    assign id_ready = !rst && !flush && (src_hazard == '0) && !dst_full;
    assign issue    = id_valid && id_ready;

    // Issue and retire to the same register cancel; flush drops the retire entirely.
    always_comb begin
        underflow = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (issue && dst_hit[r] && !wb_hit[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wb_hit[r] && !(issue && dst_hit[r])) begin
                if (cnt_q[r] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '{default: '0};
            busy_vec      <= '0;
            err_underflow <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            busy_vec      <= busy_d;
            err_underflow <= err_underflow | underflow;
            if (id_valid && !id_ready && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule
